// File: rtl/bank_stream_ctrl.sv
// Load/scan sequencer for a BANKS-wide true-dual-port BRAM array.
// Port A takes a word stream round-robin across banks; port B reads whole rows into a backpressured stream.

module bank_stream_lane #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 8,
    parameter int WE    = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [ADDR-1:0]  addr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ena_o,
    output logic [WE-1:0]    wea_o,
    output logic [ADDR-1:0]  addra_o,
    output logic [WIDTH-1:0] dina_o
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena_o   <= 1'b0;
            wea_o   <= '0;
            addra_o <= '0;
            dina_o  <= '0;
        end else begin
            ena_o   <= wr_i;
            wea_o   <= wr_i ? {WE{1'b1}} : '0;
            addra_o <= wr_i ? addr_i : '0;
            dina_o  <= wr_i ? data_i : '0;
        end
    end
endmodule

module bank_stream_ctrl #(
    parameter int BANKS = 4,
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int ADDR  = $clog2(DEPTH),
    parameter int WE    = WIDTH / 8,
    parameter int BSEL  = $clog2(BANKS),
    parameter int LEN_W = ADDR + BSEL + 1,
    parameter int OBUF  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic [LEN_W-1:0]       load_len,
    input  logic [WIDTH-1:0]       s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    output logic                   s_tready,
    input  logic                   rd_start,
    input  logic [ADDR:0]          rd_len,
    output logic [BANKS*WIDTH-1:0] m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic                   busy,
    output logic                   load_done,
    output logic                   rd_done,
    output logic                   load_err,
    output logic [BANKS-1:0]       ena,
    output logic [BANKS*WE-1:0]    wea,
    output logic [BANKS*ADDR-1:0]  addra,
    output logic [BANKS*WIDTH-1:0] dina,
    output logic [BANKS-1:0]       enb,
    output logic [BANKS*ADDR-1:0]  addrb,
    input  logic [BANKS*WIDTH-1:0] doutb,
    input  logic [BANKS-1:0]       validb
);
    localparam int CW = $clog2(OBUF + 1);
    localparam int PW = (OBUF > 1) ? $clog2(OBUF) : 1;
    localparam logic [LEN_W-1:0] MAX_LOAD = LEN_W'(BANKS * DEPTH);
    localparam logic [ADDR:0]    MAX_ROWS = (ADDR + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DRAIN} state_t;

    typedef struct packed {
        logic                   last;
        logic [BANKS*WIDTH-1:0] data;
    } row_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] wc_q, wc_d, llen_q, llen_d;
    logic [ADDR:0]    rc_q, rc_d, rlen_q, rlen_d, cap_q, cap_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, infl_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    row_t             fifo_q [OBUF];

    logic          s_hs, issue, push, pop;
    logic [ADDR:0] rd_len_c;
    logic          unused_validb;

    // All banks read in lockstep, so bank 0's valid stands for the whole row.
    assign unused_validb = ^validb;

    assign rd_len_c  = (rd_len > MAX_ROWS) ? MAX_ROWS : rd_len;
    assign s_tready  = (state_q == LOAD) && (wc_q != llen_q);
    assign s_hs      = s_tready && s_tvalid;
    assign issue     = (state_q == SCAN) && (rc_q != rlen_q) &&
                       (({1'b0, cnt_q} + {1'b0, infl_q}) < (CW + 1)'(OBUF));
    // A row with nothing outstanding is a leftover from before reset.
    assign push      = validb[0] && (infl_q != '0);
    assign m_tvalid  = (cnt_q != '0);
    assign pop       = m_tvalid && m_tready;
    assign m_tdata   = m_tvalid ? fifo_q[rd_ptr_q].data : '0;
    assign m_tlast   = m_tvalid && fifo_q[rd_ptr_q].last;
    assign load_done = (state_q == LOAD) && (wc_q == llen_q);
    assign rd_done   = (state_q == DRAIN) && (cnt_q == '0) && (infl_q == '0);
    assign busy      = (state_q != IDLE) || (cnt_q != '0);
    assign load_err  = err_q;
    assign enb       = {BANKS{issue}};
    assign addrb     = issue ? {BANKS{rc_q[ADDR-1:0]}} : '0;

    for (genvar i = 0; i < BANKS; i++) begin : g_lane
        bank_stream_lane #(.WIDTH(WIDTH), .ADDR(ADDR), .WE(WE)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .wr_i    (s_hs && (wc_q[BSEL-1:0] == BSEL'(i))),
            .addr_i  (wc_q[LEN_W-2:BSEL]),
            .data_i  (s_tdata),
            .ena_o   (ena[i]),
            .wea_o   (wea[i*WE +: WE]),
            .addra_o (addra[i*ADDR +: ADDR]),
            .dina_o  (dina[i*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        llen_d  = llen_q;
        err_d   = err_q;
        rc_d    = rc_q;
        rlen_d  = rlen_q;
        cap_d   = push ? cap_q + 1'b1 : cap_q;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    wc_d    = '0;
                    // Oversized loads become zero-length loads flagged as errors.
                    err_d   = (load_len > MAX_LOAD);
                    llen_d  = (load_len > MAX_LOAD) ? '0 : load_len;
                end else if (rd_start) begin
                    state_d = (rd_len_c == '0) ? DRAIN : SCAN;
                    rc_d    = '0;
                    cap_d   = '0;
                    rlen_d  = rd_len_c;
                end
            end
            LOAD: begin
                if (s_hs) begin
                    wc_d = wc_q + 1'b1;
                    if (s_tlast != (wc_q == llen_q - 1'b1)) err_d = 1'b1;
                end
                if (wc_q == llen_q) state_d = IDLE;
            end
            SCAN: begin
                if (issue) rc_d = rc_q + 1'b1;
                if (rc_q == rlen_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (rd_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wc_q     <= '0;
            llen_q   <= '0;
            err_q    <= 1'b0;
            rc_q     <= '0;
            rlen_q   <= '0;
            cap_q    <= '0;
            cnt_q    <= '0;
            infl_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            llen_q  <= llen_d;
            err_q   <= err_d;
            rc_q    <= rc_d;
            rlen_q  <= rlen_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_q + CW'(push) - CW'(pop);
            infl_q  <= infl_q + CW'(issue) - CW'(push);
            if (push) wr_ptr_q <= (wr_ptr_q == PW'(OBUF - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(OBUF - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    // Row storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{last: (cap_q == rlen_q - 1'b1), data: doutb};
    end
endmodule

// File: tb/tb_bank_stream_ctrl.sv
// Directed bench for bank_stream_ctrl with a 4-bank, 2-cycle-read BRAM model.

module tb_bank_stream_ctrl;
    localparam int BANKS = 4, WIDTH = 16, DEPTH = 256, ADDR = 8, WE = 2, LEN_W = 11, OBUF = 4;

    logic clk = 1'b0, rst = 1'b1, mem_init = 1'b1;
    logic load_start = 0, s_tvalid = 0, s_tlast = 0, rd_start = 0, m_tready = 0;
    logic [LEN_W-1:0] load_len = '0;
    logic [WIDTH-1:0] s_tdata = '0;
    logic [ADDR:0]    rd_len = '0;
    logic s_tready, m_tvalid, m_tlast, busy, load_done, rd_done, load_err;
    logic [BANKS*WIDTH-1:0] m_tdata, dina, doutb;
    logic [BANKS-1:0]       ena, enb, validb;
    logic [BANKS*WE-1:0]    wea;
    logic [BANKS*ADDR-1:0]  addra, addrb;

    always #5 clk = ~clk;

    bank_stream_ctrl dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .rd_start(rd_start), .rd_len(rd_len), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tready(m_tready), .busy(busy), .load_done(load_done),
        .rd_done(rd_done), .load_err(load_err), .ena(ena), .wea(wea), .addra(addra),
        .dina(dina), .enb(enb), .addrb(addrb), .doutb(doutb), .validb(validb)
    );

    // Bank model: byte-enabled writes, two-cycle registered reads.
    logic [WIDTH-1:0] mem [BANKS][DEPTH];
    logic [1:0]       vld_pipe;
    logic [ADDR-1:0]  ap [BANKS];
    logic [WIDTH-1:0] dr [BANKS];

    always @(posedge clk) begin
        vld_pipe <= {vld_pipe[0], enb[0]};
        for (int b = 0; b < BANKS; b++) begin
            ap[b] <= addrb[b*ADDR +: ADDR];
            dr[b] <= mem[b][ap[b]];
            if (mem_init) begin
                for (int a = 0; a < DEPTH; a++) mem[b][a] <= 16'hA000 | 16'(b << 8) | 16'(a);
            end else if (ena[b] && wea[b*WE +: WE] == 2'b11) begin
                mem[b][addra[b*ADDR +: ADDR]] <= dina[b*WIDTH +: WIDTH];
            end
        end
    end
    assign validb = {BANKS{vld_pipe[1]}};
    for (genvar g = 0; g < BANKS; g++) begin : g_dout
        assign doutb[g*WIDTH +: WIDTH] = dr[g];
    end

    // Monitor: event counters, beat log, occupancy and stall stability.
    int wr_cnt = 0, ld_cnt = 0, rdd_cnt = 0, enb_cnt = 0, outst = 0, outst_max = 0, stall_bad = 0;
    logic [63:0] beats_d[$];
    logic        beats_l[$];
    logic        pv = 0, pr = 0;
    logic [63:0] pd = '0;

    always @(negedge clk) begin
        if (!rst) begin
            for (int b = 0; b < BANKS; b++) wr_cnt += int'(ena[b]);
            ld_cnt  += int'(load_done);
            rdd_cnt += int'(rd_done);
            enb_cnt += int'(enb[0]);
            outst   += int'(enb[0]) - int'(m_tvalid && m_tready);
            if (outst > outst_max) outst_max = outst;
            if (pv && !pr && (!m_tvalid || m_tdata != pd)) stall_bad++;
            if (m_tvalid && m_tready) begin
                beats_d.push_back(m_tdata);
                beats_l.push_back(m_tlast);
            end
            pv = m_tvalid; pr = m_tready; pd = m_tdata;
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_go(input int len);
        load_start = 1; load_len = LEN_W'(len); tick(); load_start = 0;
    endtask

    task automatic rd_go(input int len);
        rd_start = 1; rd_len = (ADDR + 1)'(len); tick(); rd_start = 0;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        logic hs;
        int   n;
        hs = 0; n = 0;
        s_tdata = d; s_tvalid = 1; s_tlast = last;
        while (!hs && n < 50) begin
            @(negedge clk); hs = s_tready; tick(); n++;
        end
        if (!hs) chk("send_timeout", 64'd0, 64'd1);
        s_tvalid = 0; s_tlast = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) chk(tag, 64'd1, 64'd0);
        tick();
    endtask

    function automatic logic [15:0] exp_w(input int b, input int a);
        return (a < 2) ? 16'(16'h10 + a * 4 + b) : (16'hA000 | 16'(b << 8) | 16'(a));
    endfunction

    int w0, l0, r0, e0, bi, tv, n;
    logic [63:0] row;

    initial begin
        #3;
        chk("rst_ctl", {s_tready, m_tvalid, m_tlast, busy, load_done, rd_done, load_err}, 64'd0);
        chk("rst_ena", {ena, wea}, 64'd0);
        chk("rst_enb", {enb, addrb}, 64'd0);
        chk("rst_addra", addra, 64'd0);
        chk("rst_dina", dina, 64'd0);
        #19 rst = 0;
        tick(); mem_init = 0; tick();

        // Eight-word load with a correct tlast.
        w0 = wr_cnt; l0 = ld_cnt;
        load_go(8);
        for (int i = 0; i < 8; i++) send(16'(16'h10 + i), i == 7);
        wait_idle("ld8_timeout");
        tick();
        chk("ld8_b0a0", mem[0][0], 64'h10);
        chk("ld8_b0a1", mem[0][1], 64'h14);
        chk("ld8_b3a0", mem[3][0], 64'h13);
        chk("ld8_b3a1", mem[3][1], 64'h17);
        chk("ld8_writes", wr_cnt - w0, 64'd8);
        chk("ld8_done", ld_cnt - l0, 64'd1);
        chk("ld8_err", load_err, 64'd0);

        // Two-row scan, no backpressure.
        m_tready = 1; bi = beats_d.size(); r0 = rdd_cnt;
        rd_go(2);
        wait_idle("rd2_timeout");
        chk("rd2_beats", beats_d.size() - bi, 64'd2);
        if (beats_d.size() >= bi + 2) begin
            chk("rd2_beat0", beats_d[bi], 64'h0013_0012_0011_0010);
            chk("rd2_last0", beats_l[bi], 64'd0);
            chk("rd2_beat1", beats_d[bi+1], 64'h0017_0016_0015_0014);
            chk("rd2_last1", beats_l[bi+1], 64'd1);
        end
        chk("rd2_done", rdd_cnt - r0, 64'd1);

        // Sixteen rows with ready high one cycle in three.
        bi = beats_d.size(); r0 = rdd_cnt;
        rd_go(16);
        n = 0;
        while (rdd_cnt == r0 && n < 600) begin m_tready = (n % 3 == 0); tick(); n++; end
        m_tready = 1;
        chk("rd16_done", rdd_cnt - r0, 64'd1);
        chk("rd16_beats", beats_d.size() - bi, 64'd16);
        if (beats_d.size() >= bi + 16) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < BANKS; b++) row[b*16 +: 16] = exp_w(b, a);
                chk("rd16_data", beats_d[bi+a], row);
                chk("rd16_last", beats_l[bi+a], 64'(a == 15));
            end
        end
        chk("rd16_outst", 64'(outst_max > OBUF), 64'd0);
        chk("rd16_stall", stall_bad, 64'd0);
        tick();

        // rd_len=0: done only.
        bi = beats_d.size(); r0 = rdd_cnt;
        rd_go(0);
        wait_idle("rd0_timeout");
        chk("rd0_done", rdd_cnt - r0, 64'd1);
        chk("rd0_beats", beats_d.size() - bi, 64'd0);

        // Simultaneous starts plus a stray rd_start mid-load.
        w0 = wr_cnt; l0 = ld_cnt; r0 = rdd_cnt; e0 = enb_cnt;
        rd_start = 1; rd_len = 9'd4;
        load_go(4);
        rd_start = 0;
        send(16'h10, 0);
        rd_start = 1; send(16'h11, 0); rd_start = 0;
        send(16'h12, 0); send(16'h13, 1);
        wait_idle("coll_timeout");
        tick(); tick();
        chk("coll_writes", wr_cnt - w0, 64'd4);
        chk("coll_ldone", ld_cnt - l0, 64'd1);
        chk("coll_enb", enb_cnt - e0, 64'd0);
        chk("coll_rdone", rdd_cnt - r0, 64'd0);

        // Early tlast: all words still written, sticky error.
        w0 = wr_cnt; l0 = ld_cnt;
        load_go(4);
        send(16'h10, 0); send(16'h11, 1); send(16'h12, 0); send(16'h13, 0);
        wait_idle("err_timeout");
        for (int i = 0; i < 5; i++) tick();
        chk("err_writes", wr_cnt - w0, 64'd4);
        chk("err_flag", load_err, 64'd1);
        chk("err_done", ld_cnt - l0, 64'd1);

        // Zero-length load clears the error, writes nothing.
        w0 = wr_cnt; l0 = ld_cnt;
        load_go(0);
        @(negedge clk);
        chk("ld0_pulse", load_done, 64'd1);
        wait_idle("ld0_timeout");
        chk("ld0_err", load_err, 64'd0);
        chk("ld0_writes", wr_cnt - w0, 64'd0);
        chk("ld0_done", ld_cnt - l0, 64'd1);

        // Oversize load.
        w0 = wr_cnt; l0 = ld_cnt;
        load_go(1025);
        s_tvalid = 1;
        wait_idle("big_timeout");
        s_tvalid = 0;
        chk("big_err", load_err, 64'd1);
        chk("big_writes", wr_cnt - w0, 64'd0);
        chk("big_done", ld_cnt - l0, 64'd1);

        // Reset mid-scan with reads in flight and the consumer stalled.
        m_tready = 0;
        rd_go(16);
        n = 0;
        @(negedge clk);
        while (!enb[0] && n < 20) begin @(negedge clk); n++; end
        chk("mid_issue", enb[0], 64'd1);
        @(posedge clk); #2 rst = 1;
        #1;
        chk("mid_rst_ctl", {s_tready, m_tvalid, m_tlast, busy, load_done, rd_done, load_err}, 64'd0);
        chk("mid_rst_ports", {ena, wea, enb}, 64'd0);
        #1 rst = 0;
        tv = 0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); tv += int'(m_tvalid); end
        chk("mid_tvalid", tv, 64'd0);
        chk("mid_busy", busy, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
